// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/payload bundle between four requesters, the round-robin arbiter and
// the shared output channel. slave = arbiter side, master = requesters/downstream.
interface mux4_rr_arbiter_if #(
  parameter int unsigned DW = 2
) ();
  logic [3:0]    req;
  logic [DW-1:0] p0;
  logic [DW-1:0] p1;
  logic [DW-1:0] p2;
  logic [DW-1:0] p3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] sout;
  logic          sout_vld;
  logic          sout_rdy;
  logic          busy;

  modport slave (
    input  req, p0, p1, p2, p3, sout_rdy,
    output gnt, sel, sout, sout_vld, busy
  );

  modport master (
    output req, p0, p1, p2, p3, sout_rdy,
    input  gnt, sel, sout, sout_vld, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 DW-wide output mux.
// Optional forced release after HOLD_MAX grant cycles: define MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned DW       = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] winner;
  logic       found;
  logic       release_grant;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
`endif

  // First set request searching ptr+1, ptr+2, ... with 2-bit wrap.
  always_comb begin
    logic [1:0] idx;
    found  = 1'b0;
    winner = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    release_grant = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
    hold_d        = hold_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
`ifdef MUX4_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      StGrant: begin
        release_grant = !bus.req[sel_q];
`ifdef MUX4_ARB_TIMEOUT_EN
        // Saturate at the last count so a later competing request still trips release.
        if (hold_q == HoldLast) begin
          if ((bus.req & ~gnt_q) != 4'b0000) release_grant = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
        if (release_grant) begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  logic [DW-1:0] sout_mux;

  always_comb begin
    sout_mux = '0;
    if (gnt_q != 4'b0000) begin
      unique case (sel_q)
        2'd0:    sout_mux = bus.p0;
        2'd1:    sout_mux = bus.p1;
        2'd2:    sout_mux = bus.p2;
        default: sout_mux = bus.p3;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.sout     = sout_mux;
  assign bus.sout_vld = |gnt_q;
  assign bus.busy     = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a behavioural model.
// Honours MUX4_ARB_TIMEOUT_EN the same way as the design.
module tb_mux4_rr_arbiter;
  localparam int unsigned DW       = 2;
  localparam int unsigned HOLD_MAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'h0;
  logic [DW-1:0] p [4];
  logic          rdy = 1'b1;
  bit            check_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  assign bus.req      = req;
  assign bus.p0       = p[0];
  assign bus.p1       = p[1];
  assign bus.p2       = p[2];
  assign bus.p3       = p[3];
  assign bus.sout_rdy = rdy;

  mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the channel (if anyone), whose turn is next, how long held.
  bit m_granted = 1'b0;
  int m_owner   = 0;
  int m_last    = 3;
  int m_hold    = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_granted = 1'b0;
      m_owner   = 0;
      m_last    = 3;
      m_hold    = 0;
    end else if (!m_granted) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_granted && req[(m_last + k) % 4]) begin
          m_granted = 1'b1;
          m_owner   = (m_last + k) % 4;
          m_hold    = 0;
        end
      end
    end else begin
      bit give_up;
      give_up = !req[m_owner];
`ifdef MUX4_ARB_TIMEOUT_EN
      if (m_hold == HOLD_MAX - 1) begin
        for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) give_up = 1'b1;
      end else begin
        m_hold++;
      end
`endif
      if (give_up) begin
        m_granted = 1'b0;
        m_last    = m_owner;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("gnt",  32'(bus.gnt),      m_granted ? 32'(1 << m_owner) : 32'd0);
      chk("sel",  32'(bus.sel),      32'(m_owner));
      chk("vld",  32'(bus.sout_vld), 32'(m_granted));
      chk("busy", 32'(bus.busy),     32'(m_granted));
      chk("sout", 32'(bus.sout),     m_granted ? 32'(p[m_owner]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] order_exp [5];

  initial begin
    for (int i = 0; i < 4; i++) p[i] = '0;

    // Reset held two cycles with every source requesting.
    rst = 1'b1;
    req = 4'hF;
    tick();
    check_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_gnt",  32'(bus.gnt), 32'd0);
      chk("rst_sel",  32'(bus.sel), 32'd0);
      chk("rst_vld",  32'(bus.sout_vld), 32'd0);
      chk("rst_sout", 32'(bus.sout), 32'd0);
      if (c == 0) tick();
    end

    // Single request from source 2.
    rst  = 1'b0;
    req  = 4'b0100;
    p[2] = 2'b11;
    rdy  = 1'b1;
    tick();
    chk("single_gnt",  32'(bus.gnt), 32'h4);
    chk("single_sel",  32'(bus.sel), 32'd2);
    chk("single_sout", 32'(bus.sout), 32'h3);
    req = 4'b0000;
    tick();
    chk("single_drop", 32'(bus.gnt), 32'h0);

    // Round robin from reset pointer: 0,1,2,3,0 with an idle cycle between.
    do_reset();
    order_exp[0] = 4'b0001;
    order_exp[1] = 4'b0010;
    order_exp[2] = 4'b0100;
    order_exp[3] = 4'b1000;
    order_exp[4] = 4'b0001;
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      int waited;
      waited = 0;
      while (bus.gnt == 4'h0 && waited < 8) begin
        tick();
        waited++;
      end
      chk("rr_order", 32'(bus.gnt), 32'(order_exp[g]));
      tick();
      tick();
      req = 4'hF & ~bus.gnt;
      tick();
      chk("rr_idle", 32'(bus.gnt), 32'h0);
      req = 4'hF;
    end
    req = 4'h0;
    tick();
    tick();

    // Backpressure on source 1.
    do_reset();
    req  = 4'b0010;
    p[1] = 2'b10;
    rdy  = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_vld",  32'(bus.sout_vld), 32'd1);
      chk("bp_sel",  32'(bus.sel), 32'd1);
      chk("bp_sout", 32'(bus.sout), 32'h2);
      tick();
    end
    req = 4'h0;
    rdy = 1'b1;
    tick();

    // Mid-tenure reset while source 3 is granted.
    req = 4'b1000;
    tick();
    chk("mid_gnt3", 32'(bus.gnt), 32'h8);
    rst = 1'b1;
    tick();
    chk("mid_rst", 32'(bus.gnt), 32'h0);
    rst = 1'b0;
    req = 4'hF;
    tick();
    chk("mid_first", 32'(bus.gnt), 32'h1);
    req = 4'h0;
    tick();

    // Source 0 holding while source 3 waits.
    do_reset();
    req = 4'b1001;
    tick();
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      chk("to_hold", 32'(bus.gnt), 32'h1);
      tick();
    end
    chk("to_release", 32'(bus.gnt), 32'h0);
    tick();
    chk("to_next", 32'(bus.gnt), 32'h8);
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 12; c++) begin
      chk("to_alone", 32'(bus.gnt), 32'h1);
      tick();
    end
`else
    for (int c = 0; c < 12; c++) begin
      chk("hold_forever", 32'(bus.gnt), 32'h1);
      tick();
    end
`endif
    req = 4'h0;
    tick();

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
        p[i] = DW'($urandom);
      end
      rdy = 1'($urandom);
      rst = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b0;
    req = 4'h0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
